// File: rtl/prf_read_arbiter_pkg.sv
// Shared definitions for the PRF read-port arbiter slice.
//   NUM_PREGS : number of physical registers in the core
//   ZERO_PREG : hard-wired zero physical register
//   preg_t    : physical register index type
package prf_read_arbiter_pkg;

  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned ZERO_PREG = 0;

  typedef logic [$clog2(NUM_PREGS)-1:0] preg_t;

endpackage

// File: rtl/prf_read_arbiter_rr_arbiter.sv
// Round-robin arbiter, reusable for any shared port.
//   req     : per-requester request vector
//   ptr     : highest-priority requester this cycle
//   en      : arbitration enable (no grant when low)
//   gnt     : one-hot grant
//   gnt_idx : index of the granted requester (ptr when nothing granted)
//   any     : a grant was issued
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Walk the requesters starting at ptr, wrapping modulo N; first hit wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt     = '0;
    gnt_idx = ptr;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = IDX_W'((32'(ptr) + off) % N);
      if (en && !any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/prf_read_arbiter.sv
// Shares the PRF src1/src2 read-port pair between NUM_REQ issue lanes.
// Round-robin grant, PRF read addressing, writeback forwarding and a
// single registered response with valid/ready handshake.
//   req_valid/req_src1/req_src2 : per-lane read requests (lane i at [i*PREG_W +: PREG_W])
//   req_ready                   : one-hot grant, request accepted this cycle
//   prf_src{1,2}_reg/_val       : PRF read address out, combinational data in
//   wb_valid/wb_preg/wb_data    : same-cycle PRF writeback, forwarded into captures
//   resp_*                      : registered response, one per grant
module prf_read_arbiter
  import prf_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PREG_W  = $bits(preg_t),
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*PREG_W-1:0] req_src1,
  input  logic [NUM_REQ*PREG_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [PREG_W-1:0]         prf_src1_reg,
  output logic [PREG_W-1:0]         prf_src2_reg,
  input  logic [31:0]               prf_src1_val,
  input  logic [31:0]               prf_src2_val,
  input  logic                      wb_valid,
  input  logic [PREG_W-1:0]         wb_preg,
  input  logic [31:0]               wb_data,
  output logic                      resp_valid,
  output logic [ID_W-1:0]           resp_id,
  output logic [31:0]               resp_src1_val,
  output logic [31:0]               resp_src2_val,
  input  logic                      resp_ready
);

  logic [ID_W-1:0]    rr_ptr;
  logic               can_accept;
  logic               grant_any;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [PREG_W-1:0]  lane_src1 [NUM_REQ];
  logic [PREG_W-1:0]  lane_src2 [NUM_REQ];
  logic [PREG_W-1:0]  sel_src1;
  logic [PREG_W-1:0]  sel_src2;
  logic [31:0]        op1;
  logic [31:0]        op2;

  // Zero register wins over forwarding; forwarding wins over the PRF read.
  function automatic logic [31:0] pick_operand(
    input logic [PREG_W-1:0] preg,
    input logic [31:0]       prf_val,
    input logic              fwd_valid,
    input logic [PREG_W-1:0] fwd_preg,
    input logic [31:0]       fwd_data
  );
    logic [31:0] val;
    if (preg == PREG_W'(ZERO_PREG))
      val = '0;
    else if (fwd_valid && fwd_preg == preg)
      val = fwd_data;
    else
      val = prf_val;
    return val;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lane_src1[i] = req_src1[i*PREG_W +: PREG_W];
      lane_src2[i] = req_src2[i*PREG_W +: PREG_W];
    end
  end

  assign can_accept = !resp_valid || resp_ready;

  // Gating with rst_n keeps every combinational output at 0 during reset.
  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (can_accept && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (grant_any)
  );

  assign req_ready = gnt;

  // gnt_idx falls back to rr_ptr with no grant, giving a deterministic address.
  assign sel_src1     = lane_src1[gnt_idx];
  assign sel_src2     = lane_src2[gnt_idx];
  assign prf_src1_reg = rst_n ? sel_src1 : '0;
  assign prf_src2_reg = rst_n ? sel_src2 : '0;

  assign op1 = pick_operand(sel_src1, prf_src1_val, wb_valid, wb_preg, wb_data);
  assign op2 = pick_operand(sel_src2, prf_src2_val, wb_valid, wb_preg, wb_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_src1_val <= '0;
      resp_src2_val <= '0;
    end else if (grant_any) begin
      rr_ptr        <= ID_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
      resp_valid    <= 1'b1;
      resp_id       <= gnt_idx;
      resp_src1_val <= op1;
      resp_src2_val <= op2;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prf_read_arbiter.sv
module tb_prf_read_arbiter;
  import prf_read_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int PW = $bits(preg_t);
  localparam int IW = 2;
  localparam int BW = N + 1 + IW + 64;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_src1;
  logic [N*PW-1:0] req_src2;
  logic [N-1:0]    req_ready;
  logic [PW-1:0]   prf_src1_reg;
  logic [PW-1:0]   prf_src2_reg;
  logic [31:0]     prf_src1_val;
  logic [31:0]     prf_src2_val;
  logic            wb_valid;
  logic [PW-1:0]   wb_preg;
  logic [31:0]     wb_data;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic [31:0]     resp_src1_val;
  logic [31:0]     resp_src2_val;
  logic            resp_ready;

  // Environment PRF: combinational read.
  logic [31:0] prf_mem [NUM_PREGS];
  assign prf_src1_val = prf_mem[prf_src1_reg];
  assign prf_src2_val = prf_mem[prf_src2_reg];

  prf_read_arbiter #(
    .NUM_REQ (N),
    .PREG_W  (PW),
    .ID_W    (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_src1      (req_src1),
    .req_src2      (req_src2),
    .req_ready     (req_ready),
    .prf_src1_reg  (prf_src1_reg),
    .prf_src2_reg  (prf_src2_reg),
    .prf_src1_val  (prf_src1_val),
    .prf_src2_val  (prf_src2_val),
    .wb_valid      (wb_valid),
    .wb_preg       (wb_preg),
    .wb_data       (wb_data),
    .resp_valid    (resp_valid),
    .resp_id       (resp_id),
    .resp_src1_val (resp_src1_val),
    .resp_src2_val (resp_src2_val),
    .resp_ready    (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Lane-side request state driven by the bench.
  bit            lane_v  [N];
  logic [PW-1:0] lane_s1 [N];
  logic [PW-1:0] lane_s2 [N];

  // Reference model state.
  int           m_ptr;
  bit           m_valid;
  int           m_id;
  logic [31:0]  m_v1, m_v2;
  bit           e_any;
  int           e_g;
  logic [31:0]  e_v1, e_v2;
  logic [N-1:0] e_ready;

  function automatic logic [31:0] exp_op(input logic [PW-1:0] p);
    if (p == 0) return 32'h0;
    if (wb_valid && wb_preg == p) return wb_data;
    return prf_mem[p];
  endfunction

  function automatic logic [BW-1:0] exp_bus();
    return {e_ready, m_valid, IW'(m_id), m_v1, m_v2};
  endfunction

  function automatic logic [BW-1:0] obs_bus();
    return {req_ready, resp_valid, resp_id, resp_src1_val, resp_src2_val};
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = lane_v[i];
      req_src1[i*PW +: PW]  = lane_s1[i];
      req_src2[i*PW +: PW]  = lane_s2[i];
    end
  endtask

  // Priority order is the lane list rotated to start at the pointer.
  task automatic model_eval();
    int order[$];
    order = {};
    for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
    e_any = 0;
    e_g   = 0;
    if (!m_valid || resp_ready === 1'b1)
      foreach (order[j])
        if (!e_any && lane_v[order[j]]) begin
          e_any = 1;
          e_g   = order[j];
        end
    e_v1    = exp_op(lane_s1[e_g]);
    e_v2    = exp_op(lane_s2[e_g]);
    e_ready = e_any ? N'(1 << e_g) : '0;
  endtask

  task automatic model_commit();
    if (e_any) begin
      m_valid = 1;
      m_id    = e_g;
      m_v1    = e_v1;
      m_v2    = e_v2;
      m_ptr   = (e_g + 1) % N;
    end else if (m_valid && resp_ready === 1'b1) begin
      m_valid = 0;
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_v1 = '0; m_v2 = '0;
  endtask

  task automatic settle();
    apply();
    #2;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < N; i++) begin
      lane_v[i] = 0; lane_s1[i] = '0; lane_s2[i] = '0;
    end
  endtask

  task automatic test_reset();
    clear_lanes();
    lane_v[0] = 1; lane_s1[0] = 6'd4;
    rst_n = 1'b0; resp_ready = 1'b1; wb_valid = 1'b0; wb_preg = '0; wb_data = '0;
    model_reset();
    apply();
    #2;
    n_vec++;
    if ({req_ready, resp_valid, resp_id, resp_src1_val, resp_src2_val, prf_src1_reg, prf_src2_reg}
        !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got ready=%b valid=%b id=%0d v1=%h v2=%h a1=%0d a2=%0d expected all zero",
               req_ready, resp_valid, resp_id, resp_src1_val, resp_src2_val, prf_src1_reg, prf_src2_reg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Lane 1 only, to hold a response and move the pointer off zero.
    clear_lanes();
    lane_v[1] = 1; lane_s1[1] = 6'd3; lane_s2[1] = 6'd4;
    settle();
    n_vec++;
    if (obs_bus() !== exp_bus()) begin
      n_bad++;
      $display("FAIL reset_pre_grant: got %h expected %h", obs_bus(), exp_bus());
    end
    advance();
    lane_v[1] = 0;
    resp_ready = 1'b0;
    settle();
    n_vec++;
    if (obs_bus() !== exp_bus() || resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_held_resp: got %h expected %h", obs_bus(), exp_bus());
    end
    // Reset asserted mid-cycle with a response held.
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({resp_valid, resp_id, resp_src1_val, resp_src2_val, req_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_async_drop: got valid=%b id=%0d v1=%h v2=%h ready=%b expected zeros",
               resp_valid, resp_id, resp_src1_val, resp_src2_val, req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    prf_mem[5] = 32'h11; prf_mem[7] = 32'h22;
    lane_v[0] = 1; lane_s1[0] = 6'd5; lane_s2[0] = 6'd7;
    settle();
    n_vec++;
    if (req_ready !== 3'b001 || prf_src1_reg !== 6'd5 || prf_src2_reg !== 6'd7) begin
      n_bad++;
      $display("FAIL reset_first_grant: got ready=%b a1=%0d a2=%0d expected 001/5/7",
               req_ready, prf_src1_reg, prf_src2_reg);
    end
    advance();
    lane_v[0] = 0;
    settle();
    n_vec++;
    if ({resp_valid, resp_id, resp_src1_val, resp_src2_val} !== {1'b1, 2'd0, 32'h11, 32'h22}) begin
      n_bad++;
      $display("FAIL reset_first_resp: got valid=%b id=%0d v1=%h v2=%h expected 1/0/11/22",
               resp_valid, resp_id, resp_src1_val, resp_src2_val);
    end
    advance();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      lane_v[i] = 1; lane_s1[i] = PW'(10 + i); lane_s2[i] = PW'(20 + i);
    end
    for (int k = 0; k < 7; k++) begin
      settle();
      want = N'(1 << (k % N));
      n_vec++;
      if (req_ready !== want || obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got ready=%b bus=%h expected ready=%b bus=%h",
                 k, req_ready, obs_bus(), want, exp_bus());
      end
      if (k > 0) begin
        n_vec++;
        if (resp_valid !== 1'b1 || resp_id !== IW'((k - 1) % N)) begin
          n_bad++;
          $display("FAIL rr_resp_id[%0d]: got valid=%b id=%0d expected 1/%0d",
                   k, resp_valid, resp_id, (k - 1) % N);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    clear_lanes();
    lane_v[1] = 1; lane_s1[1] = 6'd12; lane_s2[1] = 6'd13;
    lane_v[2] = 1; lane_s1[2] = 6'd14; lane_s2[2] = 6'd15;
    resp_ready = 1'b1;
    settle();
    n_vec++;
    if (obs_bus() !== exp_bus()) begin
      n_bad++;
      $display("FAIL bp_grant: got %h expected %h", obs_bus(), exp_bus());
    end
    advance();
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_vec++;
      if (req_ready !== '0 || obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("FAIL bp_stall[%0d]: got %h expected %h", k, obs_bus(), exp_bus());
      end
      advance();
    end
    resp_ready = 1'b1;
    settle();
    n_vec++;
    if (req_ready !== 3'b100 || obs_bus() !== exp_bus()) begin
      n_bad++;
      $display("FAIL bp_resume: got ready=%b bus=%h expected ready=100 bus=%h",
               req_ready, obs_bus(), exp_bus());
    end
    advance();
  endtask

  task automatic test_forwarding();
    clear_lanes();
    prf_mem[9] = 32'h0; prf_mem[3] = 32'h33;
    lane_v[2] = 1; lane_s1[2] = 6'd9; lane_s2[2] = 6'd3;
    wb_valid = 1'b1; wb_preg = 6'd9; wb_data = 32'hDEADBEEF;
    resp_ready = 1'b1;
    settle();
    n_vec++;
    if (req_ready !== 3'b100 || prf_src1_reg !== 6'd9) begin
      n_bad++;
      $display("FAIL fwd_grant: got ready=%b a1=%0d expected 100/9", req_ready, prf_src1_reg);
    end
    advance();
    lane_v[2] = 0; wb_valid = 1'b0;
    settle();
    n_vec++;
    if ({resp_valid, resp_id, resp_src1_val, resp_src2_val} !== {1'b1, 2'd2, 32'hDEADBEEF, 32'h33}) begin
      n_bad++;
      $display("FAIL fwd_resp: got valid=%b id=%0d v1=%h v2=%h expected 1/2/deadbeef/33",
               resp_valid, resp_id, resp_src1_val, resp_src2_val);
    end
    advance();
  endtask

  task automatic test_zero_preg();
    clear_lanes();
    prf_mem[0] = 32'h77;
    lane_v[0] = 1;
    wb_valid = 1'b1; wb_preg = 6'd0; wb_data = 32'h5;
    resp_ready = 1'b1;
    settle();
    advance();
    lane_v[0] = 0; wb_valid = 1'b0;
    settle();
    n_vec++;
    if ({resp_valid, resp_id, resp_src1_val, resp_src2_val} !== {1'b1, 2'd0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL zero_preg: got valid=%b id=%0d v1=%h v2=%h expected 1/0/0/0",
               resp_valid, resp_id, resp_src1_val, resp_src2_val);
    end
  endtask

  task automatic test_drop_and_hold();
    // Response from the zero-preg test is held; lane 1 waits then drops.
    clear_lanes();
    lane_v[1] = 1; lane_s1[1] = 6'd21; lane_s2[1] = 6'd22;
    resp_ready = 1'b0;
    settle();
    n_vec++;
    if (req_ready !== '0 || obs_bus() !== exp_bus()) begin
      n_bad++;
      $display("FAIL drop_wait: got %h expected %h", obs_bus(), exp_bus());
    end
    advance();
    lane_v[1] = 0;
    lane_v[0] = 1; lane_s1[0] = 6'd5; lane_s2[0] = 6'd7;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_vec++;
      if (req_ready !== 3'b001 || obs_bus() !== exp_bus() || resp_id === 2'd1) begin
        n_bad++;
        $display("FAIL lone_lane0[%0d]: got ready=%b bus=%h expected ready=001 bus=%h",
                 k, req_ready, obs_bus(), exp_bus());
      end
      advance();
    end
    for (int i = 0; i < N; i++) lane_v[i] = 1;
    settle();
    n_vec++;
    if (req_ready !== 3'b010) begin
      n_bad++;
      $display("FAIL ptr_after_lone: got ready=%b expected 010", req_ready);
    end
    advance();
  endtask

  task automatic test_random();
    clear_lanes();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!lane_v[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            lane_v[i]  = 1;
            lane_s1[i] = PW'($urandom_range(0, 7));
            lane_s2[i] = PW'($urandom_range(0, 63));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          lane_v[i] = 0;
        end
      end
      wb_valid   = 1'($urandom_range(0, 1));
      wb_preg    = PW'($urandom_range(0, 7));
      wb_data    = $urandom;
      resp_ready = ($urandom_range(0, 9) < 7);
      settle();
      n_vec++;
      if (obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("FAIL rand_bus[%0d]: got %h expected %h", c, obs_bus(), exp_bus());
      end
      if (e_any) begin
        n_vec++;
        if (prf_src1_reg !== lane_s1[e_g] || prf_src2_reg !== lane_s2[e_g]) begin
          n_bad++;
          $display("FAIL rand_addr[%0d]: got %0d/%0d expected %0d/%0d",
                   c, prf_src1_reg, prf_src2_reg, lane_s1[e_g], lane_s2[e_g]);
        end
      end
      advance();
      if (e_any) lane_v[e_g] = 0;
    end
  endtask

  initial begin
    for (int p = 0; p < NUM_PREGS; p++) prf_mem[p] = $urandom;
    req_valid = '0; req_src1 = '0; req_src2 = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_forwarding();
    test_zero_preg();
    test_drop_and_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prf_read_arbiter.md
Name: prf_read_arbiter

Overview:
- Shares the physical register file's single src1/src2 read-port pair between NUM_REQ issue lanes, such as the ALU, LSU and branch lanes.
- Arbitration is round-robin; each grant drives the PRF read addresses, captures both operands one cycle later, and applies writeback forwarding.
- Delivers one registered response per grant through a valid/ready handshake.
- Sits between the issue/reg-read stage and the physical register file.

Parameters:
- NUM_REQ, 3, number of requesting lanes (2..8).
- PREG_W, $clog2(NUM_PREGS), physical register index width; NUM_PREGS comes from CORE_PKG.
- ID_W, $clog2(NUM_REQ), requester id width.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-lane read request.
- req_src1  input  NUM_REQ*PREG_W  per-lane src1 preg; lane i occupies bits [i*PREG_W +: PREG_W].
- req_src2  input  NUM_REQ*PREG_W  per-lane src2 preg.
- req_ready  output  NUM_REQ  one-hot grant; the request is accepted this cycle.
- prf_src1_reg  output  PREG_W  PRF read address 1.
- prf_src2_reg  output  PREG_W  PRF read address 2.
- prf_src1_val  input  32  PRF read data 1, combinational from the address.
- prf_src2_val  input  32  PRF read data 2.
- wb_valid  input  1  writeback to the PRF this cycle.
- wb_preg  input  PREG_W  writeback destination.
- wb_data  input  32  writeback value.
- resp_valid  output  1  response held.
- resp_id  output  ID_W  lane that owns the response.
- resp_src1_val  output  32  operand 1.
- resp_src2_val  output  32  operand 2.
- resp_ready  input  1  consumer accepts the response.

Behaviour:
- Reset (async, rst_n=0): resp_valid=0, resp_id=0, resp_src1_val=0, resp_src2_val=0, rr_ptr=0.
  - Combinational outputs are 0 while in reset.
  - Deassertion is synchronised by the top level.
  - Reset mid-transaction drops any held response.
- can_accept = !resp_valid || resp_ready (output register free or draining this cycle).
- Arbitration (combinational):
  - When can_accept, grant the first lane with req_valid=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready is one-hot for that lane; otherwise req_ready=0.
  - req_ready never depends on lanes other than through the priority search.
- Read addressing:
  - prf_src1_reg and prf_src2_reg equal the granted lane's src1/src2.
  - With no grant they equal the lane at rr_ptr (don't-care value, but deterministic).
- Capture on the grant cycle's clock edge:
  - resp_valid←1, resp_id←granted lane.
  - Each operand is selected as follows: preg==0 → 32'h0; else wb_valid && wb_preg==preg → wb_data; else the PRF value.
  - The preg-0 rule wins over forwarding.
- Latency: exactly 1 cycle from grant to resp_valid.
- Pointer: on grant to lane g, rr_ptr←(g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Response drain: resp_valid && resp_ready with no new grant → resp_valid←0.
- Back-to-back:
  - Same-cycle drain plus grant overwrites the register, so throughput is 1 per cycle.
  - Stall (resp_valid && !resp_ready): no grants and all response fields stable.
  - Held values are not re-forwarded; renaming guarantees no write to a preg pending read.
- Requesters must hold req_valid and src fields stable until req_ready. A requester may drop an ungranted request.
- Fairness: a continuously valid lane is granted within NUM_REQ grant opportunities.
- A single requester keeps getting granted every can_accept cycle.

Decomposition:
- CORE_PKG: NUM_PREGS (existing), ZERO_PREG=0, and the preg_t typedef (logic [PREG_W-1:0]).
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr, en.
  - Outputs: one-hot gnt, gnt_idx, any.
  - Reusable for the other shared ports.
- Top level instantiates rr_arbiter and holds the mux, the forwarding and the response register.
- The PRF connects through the existing reg_read/phys_reg_file modport pair; the arbiter drives the reg_read side.

Test Plan:
- Reset: assert rst_n=0 mid-stream with resp_valid=1 → resp_valid=0, rr_ptr=0 immediately. After release, lane0 req src1=5, src2=7 with PRF p5=0x11, p7=0x22 → next cycle resp_valid=1, id=0, vals 0x11/0x22.
- Round-robin: all three lanes valid continuously, resp_ready=1 → grant order 0,1,2,0,1,2. resp_id sequence matches with 1-cycle lag; one response per cycle.
- Backpressure: resp_ready=0 for 4 cycles with lanes 1 and 2 valid → req_ready=0 and the response is stable for all 4 cycles. After resp_ready=1, the next grant goes to the lane after the last granted lane.
- Forwarding: grant lane2 src1=9 while wb_valid=1, wb_preg=9, wb_data=0xDEADBEEF, and PRF p9=0 → resp_src1_val=0xDEADBEEF; src2 is unaffected.
- Zero preg: src1=0, src2=0, with wb to preg 0 of 0x5 → both values 0.
- Drop and hold: lane1 drops req_valid before its grant → no lane1 response. A lone lane0 held valid → granted every cycle and rr_ptr stays 1.
